// File: rtl/triangle_mem_loader_pkg.sv
// rt_mem_pkg: types and constants shared by the triangle memory loader.
//   load_state_e : loader FSM states
//   load_err_e   : codes reported on the loader err port
//   *_LSB        : bit offsets of the 32-bit fields inside a 128-bit MC beat
//                  (same layout the triangle memory decodes)
package rt_mem_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_V,
        ST_CHECK,
        ST_IDX_COL,
        ST_IDX_SEND,
        ST_SEP_SEND,
        ST_VTX_COL,
        ST_VTX_SEND,
        ST_TERM_SEND,
        ST_DONE_SEND
    } load_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SID     = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } load_err_e;

    localparam logic [31:0] MC_VERTEX_FLAG = 32'h1;
    localparam int unsigned LANE_W         = 32;

    // Index beat: {sid, idx2, idx1, idx0}
    localparam int unsigned IDX0_LSB  = 0;
    localparam int unsigned IDX1_LSB  = 32;
    localparam int unsigned IDX2_LSB  = 64;
    localparam int unsigned SID_LSB   = 96;

    // Vertex beat: {flag, z, y, x}
    localparam int unsigned VX_LSB    = 0;
    localparam int unsigned VY_LSB    = 32;
    localparam int unsigned VZ_LSB    = 64;
    localparam int unsigned VFLAG_LSB = 96;

    function automatic logic is_send(input load_state_e s);
        return (s == ST_IDX_SEND) || (s == ST_SEP_SEND) || (s == ST_VTX_SEND) ||
               (s == ST_TERM_SEND) || (s == ST_DONE_SEND);
    endfunction

    function automatic logic takes_words(input load_state_e s);
        return (s == ST_IDLE) || (s == ST_HDR_V) || (s == ST_IDX_COL) || (s == ST_VTX_COL);
    endfunction

endpackage

// File: rtl/triangle_mem_loader_if.sv
// Scene-stream input and MC write port of the triangle memory loader.
//   in_data/in_valid/in_ready : 32-bit scene word stream (valid/ready)
//   data_MC/we_MC/done_MC     : 128-bit beat, beat strobe, final-beat marker
//   rdy_MC                    : credit return from the memory
// master = the loader, slave = host stream source plus memory.
interface triangle_mem_loader_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_MC;
    logic         we_MC;
    logic         done_MC;
    logic         rdy_MC;

    modport master (
        input  in_data, in_valid, rdy_MC,
        output in_ready, data_MC, we_MC, done_MC
    );

    modport slave (
        output in_data, in_valid, rdy_MC,
        input  in_ready, data_MC, we_MC, done_MC
    );
endinterface

// File: rtl/triangle_mem_loader_credit.sv
// mc_credit_tracker: owns the single MC write credit, gates the beat strobe
// and bounds the wait for credit.
//   arm     in  : loader is in a state where a fresh load may start (credit restored)
//   send    in  : loader is presenting a beat
//   rdy_MC  in  : credit return (level or one-cycle pulse)
//   we_MC   out : beat strobe, combinational so a beat can go in the cycle rdy_MC rises
//   timeout out : TIMEOUT consecutive send cycles passed without a beat
module mc_credit_tracker
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic send,
    input  logic rdy_MC,
    output logic we_MC,
    output logic timeout
);

    logic        credit;
    logic [31:0] wd_cnt;

    assign we_MC   = send & (credit | rdy_MC);
    // Fires on the TIMEOUT-th stalled cycle so the abort lands on that edge.
    assign timeout = send & ~we_MC & (wd_cnt == TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= 1'b1;
            wd_cnt <= '0;
        end else begin
            // A return seen while no beat is issued is banked, so a pulse
            // arriving during a collect phase is not lost.
            if (arm)
                credit <= 1'b1;
            else if (we_MC)
                credit <= 1'b0;
            else if (rdy_MC)
                credit <= 1'b1;

            if (arm || we_MC)
                wd_cnt <= '0;
            else if (send)
                wd_cnt <= wd_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/triangle_mem_loader.sv
// triangle_mem_loader: packs the host scene word stream into 128-bit MC beats
// and writes them to the triangle memory load port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : scene stream in, MC write port out (triangle_mem_loader_if.master)
//   busy       : load in progress (any state but IDLE)
//   load_done  : one-cycle pulse after the done beat is accepted
//   err        : last load error, sticky until the next header word
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | wait for header word T
// HDR_V     | wait for header word V
// CHECK     | range-check T and V, no words taken
// IDX_COL   | collect idx0, idx1, idx2, sid into lanes 0..3
// IDX_SEND  | present index beat until credit
// SEP_SEND  | present zero separator beat
// VTX_COL   | collect x, y, z into lanes 0..2, lane 3 = vertex flag
// VTX_SEND  | present vertex beat until credit
// TERM_SEND | present zero terminator beat
// DONE_SEND | present zero beat with done_MC
module triangle_mem_loader
    import rt_mem_pkg::*;
#(
    parameter int unsigned NUM_TRIANGLE = 512,
    parameter int unsigned NUM_VERTEX   = 4 * NUM_TRIANGLE,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    triangle_mem_loader_if.master bus,
    output logic                 busy,
    output logic                 load_done,
    output logic [1:0]           err
);

    load_state_e  state, next_state;
    logic [31:0]  t_cnt;
    logic [31:0]  v_cnt;
    logic [1:0]   lane;
    logic [127:0] data_q;
    logic         done_q;
    logic         in_ready_q;
    logic         busy_q;
    logic         load_done_q;
    load_err_e    err_q;

    logic send, arm, we, timeout, accept, range_bad;

    assign accept    = bus.in_valid & in_ready_q;
    assign send      = is_send(state);
    assign arm       = (state == ST_IDLE) || (state == ST_CHECK);
    assign range_bad = (t_cnt == '0) || (t_cnt > NUM_TRIANGLE) ||
                       (v_cnt == '0) || (v_cnt > NUM_VERTEX);

    assign bus.in_ready = in_ready_q;
    assign bus.data_MC  = data_q;
    assign bus.done_MC  = done_q;
    assign bus.we_MC    = we;
    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign err          = err_q;

    mc_credit_tracker #(.TIMEOUT(TIMEOUT)) u_credit (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (arm),
        .send    (send),
        .rdy_MC  (bus.rdy_MC),
        .we_MC   (we),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (accept) next_state = ST_HDR_V;
            ST_HDR_V:     if (accept) next_state = ST_CHECK;
            ST_CHECK:     next_state = range_bad ? ST_IDLE : ST_IDX_COL;
            ST_IDX_COL:
                if (accept && lane == 2'd3)
                    next_state = (bus.in_data == '0) ? ST_IDLE : ST_IDX_SEND;
            ST_IDX_SEND:
                if (timeout)  next_state = ST_IDLE;
                else if (we)  next_state = (t_cnt == 32'd1) ? ST_SEP_SEND : ST_IDX_COL;
            ST_SEP_SEND:
                if (timeout)  next_state = ST_IDLE;
                else if (we)  next_state = ST_VTX_COL;
            ST_VTX_COL:   if (accept && lane == 2'd2) next_state = ST_VTX_SEND;
            ST_VTX_SEND:
                if (timeout)  next_state = ST_IDLE;
                else if (we)  next_state = (v_cnt == 32'd1) ? ST_TERM_SEND : ST_VTX_COL;
            ST_TERM_SEND:
                if (timeout)  next_state = ST_IDLE;
                else if (we)  next_state = ST_DONE_SEND;
            ST_DONE_SEND:
                if (timeout || we) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // in_ready and busy are registered from next_state so they read 0 while
    // in reset yet still track the current state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cnt       <= '0;
            v_cnt       <= '0;
            lane        <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            in_ready_q  <= takes_words(next_state);
            busy_q      <= (next_state != ST_IDLE);
            load_done_q <= 1'b0;

            case (state)
                ST_IDLE:
                    if (accept) begin
                        t_cnt <= bus.in_data;
                        err_q <= ERR_NONE;
                    end
                ST_HDR_V:
                    if (accept) v_cnt <= bus.in_data;
                ST_CHECK: begin
                    lane <= '0;
                    if (range_bad) err_q <= ERR_RANGE;
                end
                ST_IDX_COL:
                    if (accept) begin
                        data_q[{lane, 5'd0} +: LANE_W] <= bus.in_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3 && bus.in_data == '0) err_q <= ERR_SID;
                    end
                ST_IDX_SEND:
                    if (we) begin
                        t_cnt <= t_cnt - 32'd1;
                        // Last index beat: the separator beat that follows is all zero.
                        if (t_cnt == 32'd1) data_q <= '0;
                    end
                ST_VTX_COL:
                    if (accept) begin
                        data_q[{lane, 5'd0} +: LANE_W] <= bus.in_data;
                        if (lane == 2'd2) begin
                            data_q[VFLAG_LSB +: LANE_W] <= MC_VERTEX_FLAG;
                            lane <= '0;
                        end else begin
                            lane <= lane + 2'd1;
                        end
                    end
                ST_VTX_SEND:
                    if (we) begin
                        v_cnt <= v_cnt - 32'd1;
                        if (v_cnt == 32'd1) data_q <= '0;
                    end
                ST_TERM_SEND:
                    if (we) done_q <= 1'b1;
                ST_DONE_SEND:
                    if (we) begin
                        done_q      <= 1'b0;
                        load_done_q <= 1'b1;
                    end
                default: ;
            endcase

            if (timeout) begin
                err_q  <= ERR_TIMEOUT;
                done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_triangle_mem_loader.sv
module tb_triangle_mem_loader;
    import rt_mem_pkg::*;

    localparam int NT = 512;
    localparam int NV = 4 * NT;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, load_done;
    logic [1:0] err;

    triangle_mem_loader_if bus();

    triangle_mem_loader #(.NUM_TRIANGLE(NT), .NUM_VERTEX(NV), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Receiver: records every beat, counts load_done pulses and returns one
    // rdy_MC pulse per beat, 4 cycles after index beats and 1 after others.
    logic [128:0] beats[$];
    int           ld_cnt = 0;
    bit           rx_en  = 1'b1;
    int           rx_tri = 0;

    initial begin
        int delay;
        int cnt;
        delay = 0;
        cnt   = 0;
        bus.rdy_MC = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) delay = 0;
            if (!rst_n || !busy) cnt = 0;
            if (bus.we_MC) begin
                beats.push_back({bus.done_MC, bus.data_MC});
                if (rx_en) delay = (cnt < rx_tri) ? 4 : 1;
                cnt++;
            end
            if (load_done) ld_cnt++;
            @(posedge clk);
            #1;
            bus.rdy_MC = 1'b0;
            if (delay > 0) begin
                delay--;
                if (delay == 0 && rx_en) bus.rdy_MC = 1'b1;
            end
        end
    end

    // Stream under test and the beats/error the loader must produce for it.
    logic [31:0]  stream[$];
    logic [128:0] exp_beats[$];
    logic [1:0]   exp_err;

    function automatic logic [31:0] rnd_nz();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'd0) w = 32'd1;
        return w;
    endfunction

    // Header, then t triangles (optionally with a zero sid at triangle zero_tri,
    // where the stream ends), then v vertices. Out-of-range headers stand alone.
    task automatic make_stream(input int unsigned t, input int unsigned v, input int zero_tri);
        stream.delete();
        stream.push_back(t);
        stream.push_back(v);
        if (t == 0 || t > NT || v == 0 || v > NV) return;
        for (int i = 0; i < int'(t); i++) begin
            stream.push_back($urandom);
            stream.push_back($urandom);
            stream.push_back($urandom);
            if (i == zero_tri) begin
                stream.push_back(32'd0);
                return;
            end
            stream.push_back(rnd_nz());
        end
        for (int j = 0; j < int'(v); j++) begin
            stream.push_back($urandom);
            stream.push_back($urandom);
            stream.push_back($urandom);
        end
    endtask

    // Reference model: walks the stream by the load rules.
    task automatic build_expected(input logic [31:0] t, input logic [31:0] v);
        logic [127:0] b;
        int           k;
        exp_beats.delete();
        exp_err = 2'd0;
        if (t == 0 || t > NT || v == 0 || v > NV) begin
            exp_err = 2'd2;
            return;
        end
        for (int i = 0; i < int'(t); i++) begin
            k = 2 + 4 * i;
            if (stream[k + 3] == 32'd0) begin
                exp_err = 2'd1;
                return;
            end
            b = '0;
            b[IDX0_LSB +: 32] = stream[k];
            b[IDX1_LSB +: 32] = stream[k + 1];
            b[IDX2_LSB +: 32] = stream[k + 2];
            b[SID_LSB  +: 32] = stream[k + 3];
            exp_beats.push_back({1'b0, b});
        end
        exp_beats.push_back('0);
        for (int j = 0; j < int'(v); j++) begin
            k = 2 + 4 * int'(t) + 3 * j;
            b = '0;
            b[VX_LSB    +: 32] = stream[k];
            b[VY_LSB    +: 32] = stream[k + 1];
            b[VZ_LSB    +: 32] = stream[k + 2];
            b[VFLAG_LSB +: 32] = 32'h1;
            exp_beats.push_back({1'b0, b});
        end
        exp_beats.push_back('0);
        exp_beats.push_back({1'b1, 128'd0});
    endtask

    // Offers one word and holds it until accepted; random idle gaps first.
    task automatic feed(input logic [31:0] w, input int gap, output bit ok);
        int g;
        g = 0;
        while (gap > 0 && g < 8 && int'($urandom_range(99)) < gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            g++;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input int gap, input int first);
        int b0, l0, n, got, bad, exp_ld;
        bit ok, all_ok;
        build_expected(stream[0], stream[1]);
        rx_tri = int'(stream[0] > NT ? NT : stream[0]);
        b0 = beats.size();
        l0 = ld_cnt;
        all_ok = 1'b1;
        for (int i = first; i < stream.size(); i++) begin
            feed(stream[i], gap, ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
        end
        n_checks++;
        if (!all_ok) begin
            n_fail++;
            $display("FAIL %s stream_accept: stream stalled, required all %0d words taken", name, stream.size());
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s settle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        repeat (3) @(negedge clk);
        got = beats.size() - b0;
        bad = -1;
        if (got != exp_beats.size()) bad = -2;
        else
            for (int i = 0; i < got; i++)
                if (beats[b0 + i] !== exp_beats[i]) begin
                    bad = i;
                    break;
                end
        n_checks++;
        if (bad == -2) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d beats, required %0d", name, got, exp_beats.size());
        end else if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s beat[%0d]: got %h, required %h", name, bad, beats[b0 + bad], exp_beats[bad]);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %0d, required %0d", name, err, exp_err);
        end
        exp_ld = (exp_err == 2'd0) ? 1 : 0;
        n_checks++;
        if (ld_cnt - l0 != exp_ld) begin
            n_fail++;
            $display("FAIL %s load_done: got %0d pulses, required %0d", name, ld_cnt - l0, exp_ld);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.we_MC, bus.done_MC, busy, load_done, err, bus.data_MC} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b we=%b done=%b busy=%b load_done=%b err=%0d data=%h, required all 0",
                     bus.in_ready, bus.we_MC, bus.done_MC, busy, load_done, err, bus.data_MC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || err !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b busy=%b err=%0d, required 1 0 0", bus.in_ready, busy, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        stream.delete();
        stream.push_back(32'd1);
        stream.push_back(32'd3);
        stream.push_back(32'd0);
        stream.push_back(32'd1);
        stream.push_back(32'd2);
        stream.push_back(32'd7);
        for (int i = 0; i < 9; i++) stream.push_back(32'h1000 + i);
        run_load("basic", 0, 0);
    endtask

    task automatic test_sid_zero();
        make_stream(2, 4, 1);
        run_load("sid_zero", 0, 0);
    endtask

    task automatic test_range();
        int  b0;
        bit  ok;
        make_stream(NT + 1, 1, -1);
        b0 = beats.size();
        feed(stream[0], 0, ok);
        feed(stream[1], 0, ok);
        @(negedge clk);
        n_checks++;
        if (err !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL range_check_cycle: err=%0d busy=%b, required 0 1", err, busy);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 2'd2 || busy !== 1'b0 || beats.size() != b0) begin
            n_fail++;
            $display("FAIL range_result: err=%0d busy=%b beats=%0d, required 2 0 0", err, busy, beats.size() - b0);
        end
        @(posedge clk);
        #1;
        make_stream(0, 5, -1);       run_load("range_t0", 0, 0);
        make_stream(3, 0, -1);       run_load("range_v0", 0, 0);
        make_stream(2, NV + 1, -1);  run_load("range_vmax", 0, 0);
        make_stream(32'hFFFF_FFFF, 2, -1); run_load("range_thuge", 0, 0);
    endtask

    task automatic test_max();
        make_stream(NT, NV, -1);
        run_load("max_load", 0, 0);
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 6; it++) begin
            make_stream($urandom_range(1, 5), $urandom_range(1, 9), -1);
            run_load("gaps", 35, 0);
        end
        make_stream(3, 4, 2);
        run_load("gaps_sid_zero", 35, 0);
    endtask

    task automatic test_timeout();
        int n, b0;
        bit seen, ok;
        rx_en = 1'b0;
        make_stream(1, 1, -1);
        rx_tri = 1;
        b0 = beats.size();
        for (int i = 0; i < 6; i++) feed(stream[i], 0, ok);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.we_MC) begin
                seen = 1'b1;
                break;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (err !== 2'd3 && n < TO + 50);
        // err lands on the TIMEOUT-th clock edge after the edge that took the beat.
        n_checks++;
        if (!seen || n != TO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: first beat seen=%b, err=3 after %0d samples, required %0d", seen, n, TO + 1);
        end
        n_checks++;
        if (busy !== 1'b0 || beats.size() - b0 != 1) begin
            n_fail++;
            $display("FAIL timeout_abort: busy=%b beats=%0d, required 0 1", busy, beats.size() - b0);
        end
        @(posedge clk);
        #1;
        rx_en = 1'b1;
        make_stream(2, 3, -1);
        rx_tri = 2;
        feed(stream[0], 0, ok);
        @(negedge clk);
        n_checks++;
        if (err !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_err_clear: err=%0d after header, required 0", err);
        end
        @(posedge clk);
        #1;
        run_load("after_timeout", 0, 1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        make_stream(2, 4, -1);
        rx_tri = 2;
        for (int i = 0; i < 12; i++) feed(stream[i], 0, ok);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1 || bus.we_MC !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_precond: in_ready=%b busy=%b we=%b, required 1 1 0", bus.in_ready, busy, bus.we_MC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.we_MC, bus.done_MC, busy, load_done, err, bus.data_MC} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: in_ready=%b we=%b done=%b busy=%b load_done=%b err=%0d data=%h, required all 0",
                     bus.in_ready, bus.we_MC, bus.done_MC, busy, load_done, err, bus.data_MC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        make_stream(3, 5, -1);
        run_load("post_reset", 0, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_time_limit: simulation did not end, required completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        test_reset();
        test_basic();
        test_sid_zero();
        test_range();
        test_gaps();
        test_timeout();
        test_reset_mid();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
